lcd_8080_if: RTL and testbench

- Avalon-MM slave peripheral on the Nios system bus.
- Drives a 16-bit Intel-8080-style parallel LCD controller (ILI9341 class) on the board.
- Sits directly downstream of the system interconnect: CPU or DMA writes commands and pixel data held in SDRAM, and this block serialises them onto the LCD bus.
- Includes a small write FIFO so CPU/DMA bursts do not stall on LCD bus timing.

---
 rtl/lcd_8080_pkg.sv | 37 +++
 rtl/lcd_8080_if_if.sv | 21 ++
 rtl/lcd_wr_fifo.sv | 51 +++++
 rtl/lcd_8080_if.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_8080_if.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_8080_pkg.sv
// Shared types and constants for the 8080-style LCD bus peripheral.
package lcd_8080_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LOW,
    ST_WR_HIGH,
    ST_RD_LOW,
    ST_RD_HIGH
  } lcd_state_e;

  localparam int AVS_AW = 2;
  localparam int AVS_DW = 32;

  localparam logic [1:0] ADDR_CMD   = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_RDATA = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_RESET_N = 16;

  typedef struct packed {
    logic        dc;
    logic [15:0] d;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // FIFO level as reported in the status word, clipped to 8 bits
  function automatic logic [7:0] sat_level(input logic [8:0] lvl);
    return (lvl > 9'd255) ? 8'hFF : lvl[7:0];
  endfunction

endpackage

// File: rtl/lcd_8080_if_if.sv
// Avalon-MM slave bus bundle for the LCD peripheral.
interface lcd_8080_avs_if;
  import lcd_8080_pkg::*;

  logic [AVS_AW-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [AVS_DW-1:0] avs_writedata;
  logic [AVS_DW-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/lcd_wr_fifo.sv
// Single-clock write FIFO; push while full is honoured only with a same-cycle pop.
module lcd_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end
endmodule

// File: rtl/lcd_8080_if.sv
// Avalon-MM slave that serialises queued commands/pixels onto a 16-bit 8080 LCD bus.
//
// state      | meaning
// -----------|-------------------------------------------------
// ST_IDLE    | bus released, waiting for FIFO data or a read
// ST_WR_LOW  | lcd_wr_n low, data driven
// ST_WR_HIGH | lcd_wr_n high, data held; chains to next entry
// ST_RD_LOW  | lcd_rd_n low, bus released, sample on last cycle
// ST_RD_HIGH | lcd_rd_n high recovery before releasing cs
module lcd_8080_if
  import lcd_8080_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int RD_LOW_CYC  = 10,
  parameter int RD_HIGH_CYC = 5
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  lcd_8080_avs_if.slave      avs,
  output logic               lcd_cs_n,
  output logic               lcd_dc,
  output logic               lcd_wr_n,
  output logic               lcd_rd_n,
  output logic               lcd_reset_n,
  output logic [15:0]        lcd_d_out,
  output logic               lcd_d_oe,
  input  logic [15:0]        lcd_d_in
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  lcd_state_e  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        cs_n_nx, dc_nx, wr_n_nx, rd_n_nx, reset_n_nx, oe_nx;
  logic [15:0] d_out_nx;
  logic [31:0] readdata_q, readdata_nx;
  logic        rd_done, rd_done_nx;
  logic        reg_ack, reg_ack_nx;

  fifo_entry_t w_entry;
  fifo_entry_t head;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  logic        wr_sel, rd_pend, reg_rd, busy;
  logic [31:0] status_word, reg_val;
  logic [15:0] unused_wdata;

  assign unused_wdata = avs.avs_writedata[31:16];

  assign wr_sel    = (avs.avs_address == ADDR_CMD) || (avs.avs_address == ADDR_DATA);
  assign fifo_push = avs.avs_write && wr_sel && !fifo_full;
  assign w_entry.dc = (avs.avs_address == ADDR_DATA);
  assign w_entry.d  = avs.avs_writedata[15:0];

  // rd_done masks the request in the cycle the master sees waitrequest drop
  assign rd_pend = avs.avs_read && !avs.avs_write && (avs.avs_address == ADDR_RDATA) && !rd_done;
  assign reg_rd  = avs.avs_read && !avs.avs_write && (avs.avs_address != ADDR_RDATA);

  assign busy = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    status_word = '0;
    status_word[STAT_BUSY]                    = busy;
    status_word[STAT_FULL]                    = fifo_full;
    status_word[STAT_LVL_LSB +: 8]            = sat_level(9'(fifo_level));
    status_word[STAT_RESET_N]                 = lcd_reset_n;
  end

  assign reg_val = (avs.avs_address == ADDR_CTRL) ? status_word : 32'h0;

  lcd_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .wdata (w_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // waitrequest: FIFO backpressure on queue writes, wait states on reads
  always_comb begin
    avs.avs_waitrequest = 1'b0;
    if (avs.avs_write) begin
      if (wr_sel) avs.avs_waitrequest = fifo_full;
    end else if (avs.avs_read) begin
      if (avs.avs_address == ADDR_RDATA) avs.avs_waitrequest = !rd_done;
      else                               avs.avs_waitrequest = !reg_ack;
    end
  end

  assign avs.avs_readdata = readdata_q;

  // next-state and next-output logic; one down-counter times every phase
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cs_n_nx     = lcd_cs_n;
    dc_nx       = lcd_dc;
    wr_n_nx     = lcd_wr_n;
    rd_n_nx     = lcd_rd_n;
    oe_nx       = lcd_d_oe;
    d_out_nx    = lcd_d_out;
    reset_n_nx  = lcd_reset_n;
    readdata_nx = readdata_q;
    rd_done_nx  = 1'b0;
    reg_ack_nx  = 1'b0;
    fifo_pop    = 1'b0;

    if (avs.avs_write && (avs.avs_address == ADDR_CTRL)) reset_n_nx = avs.avs_writedata[0];

    if (reg_rd && !reg_ack) begin
      reg_ack_nx  = 1'b1;
      readdata_nx = reg_val;
    end

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          d_out_nx = head.d;
          dc_nx    = head.dc;
          oe_nx    = 1'b1;
          cs_n_nx  = 1'b0;
          wr_n_nx  = 1'b0;
          cnt_nx   = 16'(WR_LOW_CYC - 1);
          state_nx = ST_WR_LOW;
        end else if (rd_pend) begin
          oe_nx    = 1'b0;
          dc_nx    = 1'b1;
          cs_n_nx  = 1'b0;
          rd_n_nx  = 1'b0;
          cnt_nx   = 16'(RD_LOW_CYC - 1);
          state_nx = ST_RD_LOW;
        end
      end
      ST_WR_LOW: begin
        if (cnt == '0) begin
          wr_n_nx  = 1'b1;
          cnt_nx   = 16'(WR_HIGH_CYC - 1);
          state_nx = ST_WR_HIGH;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      ST_WR_HIGH: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            d_out_nx = head.d;
            dc_nx    = head.dc;
            wr_n_nx  = 1'b0;
            cnt_nx   = 16'(WR_LOW_CYC - 1);
            state_nx = ST_WR_LOW;
          end else begin
            cs_n_nx  = 1'b1;
            oe_nx    = 1'b0;
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      ST_RD_LOW: begin
        if (cnt == '0) begin
          readdata_nx = {16'h0, lcd_d_in};
          rd_n_nx     = 1'b1;
          cnt_nx      = 16'(RD_HIGH_CYC - 1);
          state_nx    = ST_RD_HIGH;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      ST_RD_HIGH: begin
        if (cnt == '0) begin
          cs_n_nx    = 1'b1;
          rd_done_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // state, timer and registered pin outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lcd_cs_n    <= 1'b1;
      lcd_dc      <= 1'b1;
      lcd_wr_n    <= 1'b1;
      lcd_rd_n    <= 1'b1;
      lcd_reset_n <= 1'b0;
      lcd_d_out   <= '0;
      lcd_d_oe    <= 1'b0;
      readdata_q  <= '0;
      rd_done     <= 1'b0;
      reg_ack     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      lcd_cs_n    <= cs_n_nx;
      lcd_dc      <= dc_nx;
      lcd_wr_n    <= wr_n_nx;
      lcd_rd_n    <= rd_n_nx;
      lcd_reset_n <= reset_n_nx;
      lcd_d_out   <= d_out_nx;
      lcd_d_oe    <= oe_nx;
      readdata_q  <= readdata_nx;
      rd_done     <= rd_done_nx;
      reg_ack     <= reg_ack_nx;
    end
  end
endmodule

// File: tb/tb_lcd_8080_if.sv
// Directed self-checking bench for lcd_8080_if.
module tb_lcd_8080_if;
  import lcd_8080_pkg::*;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        lcd_cs_n, lcd_dc, lcd_wr_n, lcd_rd_n, lcd_reset_n, lcd_d_oe;
  logic [15:0] lcd_d_out, lcd_d_in;
  int          total = 0;
  int          bad = 0;

  lcd_8080_avs_if bus ();

  always #5 clk_clk = ~clk_clk;

  lcd_8080_if #(
    .FIFO_DEPTH  (16),
    .WR_LOW_CYC  (2),
    .WR_HIGH_CYC (2),
    .RD_LOW_CYC  (10),
    .RD_HIGH_CYC (5)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .avs         (bus.slave),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_dc      (lcd_dc),
    .lcd_wr_n    (lcd_wr_n),
    .lcd_rd_n    (lcd_rd_n),
    .lcd_reset_n (lcd_reset_n),
    .lcd_d_out   (lcd_d_out),
    .lcd_d_oe    (lcd_d_oe),
    .lcd_d_in    (lcd_d_in)
  );

  // LCD bus monitor, sampled mid-cycle
  logic [16:0] wr_q[$];
  int          wr_low_q[$];
  int          wr_high_q[$];
  int          cs_fall_cnt = 0;
  int          low_run = 0, high_run = 0;
  logic        prev_wr_n = 1'b1, prev_cs_n = 1'b1;
  logic [16:0] cur_word = '0;
  bit          rd_seen = 0, rd_closed = 0, rd_oe_bad = 0, rd_dc_bad = 0;
  int          rd_low_len = 0, rd_high_len = 0, wr_cnt_at_rd = -1;

  always @(negedge clk_clk) begin
    if (prev_cs_n && !lcd_cs_n) cs_fall_cnt++;
    if (!lcd_wr_n) begin
      if (prev_wr_n && high_run > 0) wr_high_q.push_back(high_run);
      high_run = 0;
      cur_word = {lcd_dc, lcd_d_out};
      low_run++;
    end else begin
      if (!prev_wr_n) begin
        wr_q.push_back(cur_word);
        wr_low_q.push_back(low_run);
        low_run = 0;
      end
      if (!lcd_cs_n && lcd_rd_n) high_run++;
      else high_run = 0;
    end
    if (!lcd_rd_n) begin
      if (!rd_seen) begin
        rd_seen = 1;
        wr_cnt_at_rd = wr_q.size();
      end
      rd_low_len++;
      if (lcd_d_oe) rd_oe_bad = 1;
      if (!lcd_dc) rd_dc_bad = 1;
    end else if (rd_seen && !rd_closed) begin
      if (lcd_cs_n) rd_closed = 1;
      else rd_high_len++;
    end
    prev_wr_n = lcd_wr_n;
    prev_cs_n = lcd_cs_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic avs_idle();
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
  endtask

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d, output int waits);
    @(negedge clk_clk);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b1;
    #1;
    waits = 0;
    while (bus.avs_waitrequest && waits < 200) begin
      @(negedge clk_clk); #1;
      waits++;
    end
    @(posedge clk_clk); #1;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d, output int waits);
    @(negedge clk_clk);
    bus.avs_address = a;
    bus.avs_write   = 1'b0;
    bus.avs_read    = 1'b1;
    #1;
    waits = 0;
    while (bus.avs_waitrequest && waits < 400) begin
      @(negedge clk_clk); #1;
      waits++;
    end
    d = bus.avs_readdata;
    @(posedge clk_clk); #1;
    bus.avs_read = 1'b0;
  endtask

  task automatic wait_writes(input int target, output bit ok);
    int n = 0;
    while (!(wr_q.size() >= target && lcd_cs_n) && n < 2000) begin
      @(negedge clk_clk); #1;
      n++;
    end
    ok = (n < 2000);
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    avs_idle();
    repeat (3) @(posedge clk_clk);
    #1;
    total++; if (lcd_cs_n !== 1'b1)    begin bad++; $display("FAIL reset_cs_n got=%b want=1", lcd_cs_n); end
    total++; if (lcd_dc !== 1'b1)      begin bad++; $display("FAIL reset_dc got=%b want=1", lcd_dc); end
    total++; if (lcd_wr_n !== 1'b1)    begin bad++; $display("FAIL reset_wr_n got=%b want=1", lcd_wr_n); end
    total++; if (lcd_rd_n !== 1'b1)    begin bad++; $display("FAIL reset_rd_n got=%b want=1", lcd_rd_n); end
    total++; if (lcd_reset_n !== 1'b0) begin bad++; $display("FAIL reset_lcd_reset_n got=%b want=0", lcd_reset_n); end
    total++; if (lcd_d_out !== 16'h0)  begin bad++; $display("FAIL reset_d_out got=%h want=0000", lcd_d_out); end
    total++; if (lcd_d_oe !== 1'b0)    begin bad++; $display("FAIL reset_d_oe got=%b want=0", lcd_d_oe); end
    total++; if (bus.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h want=0", bus.avs_readdata); end
    total++; if (bus.avs_waitrequest !== 1'b0) begin bad++; $display("FAIL reset_waitreq got=%b want=0", bus.avs_waitrequest); end
    @(negedge clk_clk);
    reset_reset = 1'b0;
  endtask

  task automatic test_ctrl_reg();
    logic [31:0] d;
    int w, base;
    avs_rd(ADDR_CTRL, d, w);
    total++; if (w !== 1) begin bad++; $display("FAIL ctrl_idle_waits got=%0d want=1", w); end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_idle_status got=%h want=00000000", d); end
    avs_wr(ADDR_CTRL, 32'h1, w);
    avs_idle();
    total++; if (lcd_reset_n !== 1'b1) begin bad++; $display("FAIL ctrl_reset_n_set got=%b want=1", lcd_reset_n); end
    avs_rd(ADDR_CTRL, d, w);
    total++; if (d !== 32'h0001_0000) begin bad++; $display("FAIL ctrl_status_rst got=%h want=00010000", d); end
    avs_rd(ADDR_CMD, d, w);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_read_addr0 got=%h want=0", d); end
    base = wr_q.size();
    avs_wr(ADDR_RDATA, 32'h1234, w);
    avs_idle();
    total++; if (w !== 0) begin bad++; $display("FAIL ctrl_wr_addr2_waits got=%0d want=0", w); end
    repeat (6) @(negedge clk_clk);
    total++; if (wr_q.size() !== base || lcd_cs_n !== 1'b1) begin
      bad++; $display("FAIL ctrl_wr_addr2_noeffect writes=%0d want=%0d cs_n=%b", wr_q.size(), base, lcd_cs_n);
    end
  endtask

  task automatic test_cmd_data();
    int w, base, lbase, hbase, cbase;
    bit ok;
    base = wr_q.size(); lbase = wr_low_q.size(); hbase = wr_high_q.size(); cbase = cs_fall_cnt;
    avs_wr(ADDR_CMD, 32'h0000_002C, w);
    avs_wr(ADDR_DATA, 32'h0000_F800, w);
    avs_idle();
    wait_writes(base + 2, ok);
    total++; if (!ok) begin bad++; $display("FAIL cmd_data_timeout writes=%0d want=%0d", wr_q.size() - base, 2); end
    if (ok) begin
      total++; if (wr_q[base] !== 17'h0_002C) begin bad++; $display("FAIL cmd_word got=%h want=0002c", wr_q[base]); end
      total++; if (wr_q[base+1] !== 17'h1_F800) begin bad++; $display("FAIL data_word got=%h want=1f800", wr_q[base+1]); end
      total++; if (wr_low_q[lbase] !== 2 || wr_low_q[lbase+1] !== 2) begin
        bad++; $display("FAIL wr_low_len got=%0d,%0d want=2,2", wr_low_q[lbase], wr_low_q[lbase+1]);
      end
      total++; if (wr_high_q.size() !== hbase + 1 || wr_high_q[hbase] !== 2) begin
        bad++; $display("FAIL wr_high_len count=%0d want=1 len=%0d want=2", wr_high_q.size() - hbase, wr_high_q[hbase]);
      end
      total++; if (cs_fall_cnt - cbase !== 1) begin bad++; $display("FAIL cs_windows got=%0d want=1", cs_fall_cnt - cbase); end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [31:0] d;
    int w, base, to_cnt, wait_cnt;
    bit ok;
    base = wr_q.size(); to_cnt = 0; wait_cnt = 0;
    // enough writes to outrun the 4-cycle drain and fill the 16-entry FIFO
    for (int i = 0; i < N; i++) begin
      avs_wr(ADDR_DATA, 32'h1000 + i, w);
      if (w > 0) wait_cnt++;
      if (w >= 200) to_cnt++;
    end
    avs_idle();
    total++; if (to_cnt != 0) begin bad++; $display("FAIL b2b_write_timeout got=%0d want=0", to_cnt); end
    total++; if (wait_cnt == 0) begin bad++; $display("FAIL b2b_waitreq_seen got=%0d want>0", wait_cnt); end
    avs_rd(ADDR_CTRL, d, w);
    total++; if (d !== 32'h0001_1003) begin bad++; $display("FAIL b2b_status_full got=%h want=00011003", d); end
    wait_writes(base + N, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_drain_timeout got=%0d want=%0d", wr_q.size() - base, N); end
    repeat (10) @(negedge clk_clk);
    total++; if (wr_q.size() !== base + N) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", wr_q.size() - base, N); end
    if (wr_q.size() == base + N) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (wr_q[base+i] !== {1'b1, 16'(16'h1000 + i)}) begin
          bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, wr_q[base+i], {1'b1, 16'(16'h1000 + i)});
        end
      end
    end
  endtask

  task automatic test_read_after_writes();
    logic [31:0] d;
    int w, base;
    base = wr_q.size();
    lcd_d_in = 16'h9341;
    avs_wr(ADDR_DATA, 32'hA001, w);
    avs_wr(ADDR_DATA, 32'hA002, w);
    avs_wr(ADDR_DATA, 32'hA003, w);
    avs_rd(ADDR_RDATA, d, w);
    total++; if (w >= 400) begin bad++; $display("FAIL rd_timeout waits=%0d want<400", w); end
    total++; if (d !== 32'h0000_9341) begin bad++; $display("FAIL rd_data got=%h want=00009341", d); end
    total++; if (wr_cnt_at_rd !== base + 3) begin bad++; $display("FAIL rd_order writes_before=%0d want=3", wr_cnt_at_rd - base); end
    total++; if (rd_low_len !== 10) begin bad++; $display("FAIL rd_low_len got=%0d want=10", rd_low_len); end
    total++; if (rd_high_len !== 5) begin bad++; $display("FAIL rd_high_len got=%0d want=5", rd_high_len); end
    total++; if (rd_oe_bad || rd_dc_bad) begin bad++; $display("FAIL rd_oe_dc oe_bad=%0d dc_bad=%0d want=0,0", rd_oe_bad, rd_dc_bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int w, n, snap;
    for (int i = 0; i < 5; i++) avs_wr(ADDR_DATA, 32'hB000 + i, w);
    avs_idle();
    n = 0;
    while (lcd_wr_n && n < 50) begin @(negedge clk_clk); n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL rstmid_no_wr_low got=%0d want<50", n); end
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    total++; if (lcd_wr_n !== 1'b1 || lcd_cs_n !== 1'b1 || lcd_d_oe !== 1'b0) begin
      bad++; $display("FAIL rstmid_pins wr_n=%b cs_n=%b oe=%b want=1,1,0", lcd_wr_n, lcd_cs_n, lcd_d_oe);
    end
    total++; if (lcd_reset_n !== 1'b0 || lcd_d_out !== 16'h0) begin
      bad++; $display("FAIL rstmid_rst_vals reset_n=%b d_out=%h want=0,0000", lcd_reset_n, lcd_d_out);
    end
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    snap = wr_q.size();
    repeat (12) @(negedge clk_clk);
    total++; if (wr_q.size() !== snap || lcd_cs_n !== 1'b1) begin
      bad++; $display("FAIL rstmid_flushed extra_writes=%0d want=0 cs_n=%b", wr_q.size() - snap, lcd_cs_n);
    end
    avs_rd(ADDR_CTRL, d, w);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_status got=%h want=00000000", d); end
  endtask

  initial begin
    bus.avs_address   = '0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    lcd_d_in          = 16'h0;
    reset_reset       = 1'b1;
    test_reset();
    test_ctrl_reg();
    test_cmd_data();
    test_back_to_back();
    test_read_after_writes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
